// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg
// Shared definitions for the MEM/WB pipeline register slice:
//   NBITS_DEF / RBITS_DEF : default data and register-index widths
//   ZERO_REG              : index of the hard-wired zero register
//   MAX_DEPTH             : largest supported number of pipeline stages
//   mem_wb_entry_t        : one in-flight entry at the default widths
package mem_wb_pipe_pkg;

  localparam int NBITS_DEF = 32;
  localparam int RBITS_DEF = 5;
  localparam int ZERO_REG  = 0;
  localparam int MAX_DEPTH = 4;

  typedef struct packed {
    logic                 valid;
    logic                 memtoreg;
    logic                 regwrite;
    logic [RBITS_DEF-1:0] rd;
    logic [NBITS_DEF-1:0] data;
    logic [NBITS_DEF-1:0] result;
  } mem_wb_entry_t;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if
// Bundles the MEM-side inputs and WB-side outputs of mem_wb_pipe.
//   master : MEM stage / write-back consumer side (drives MEM_*, reads WB_*)
//   slave  : the pipeline register itself (reads MEM_*, drives WB_*)
// Handshake: valid-only. An entry is transferred on every rising clock edge
// where MEM_valid=1 and the pipe is neither stalled nor flushed; there is
// no ready signal, backpressure is expressed solely through i_stall.
interface mem_wb_pipe_if #(
  parameter int NBITS = 32,
  parameter int RBITS = 5
);
  logic             MEM_valid;
  logic [NBITS-1:0] MEM_data;
  logic [NBITS-1:0] MEM_result;
  logic [RBITS-1:0] MEM_rd;
  logic             MEM_memtoreg;
  logic             MEM_regwrite;

  logic             WB_valid;
  logic [NBITS-1:0] WB_data;
  logic [NBITS-1:0] WB_result;
  logic [RBITS-1:0] WB_rd;
  logic             WB_memtoreg;
  logic             WB_regwrite;
  logic [NBITS-1:0] WB_value;

  modport master (
    output MEM_valid, MEM_data, MEM_result, MEM_rd, MEM_memtoreg, MEM_regwrite,
    input  WB_valid, WB_data, WB_result, WB_rd, WB_memtoreg, WB_regwrite, WB_value
  );

  modport slave (
    input  MEM_valid, MEM_data, MEM_result, MEM_rd, MEM_memtoreg, MEM_regwrite,
    output WB_valid, WB_data, WB_result, WB_rd, WB_memtoreg, WB_regwrite, WB_value
  );
endinterface

// File: rtl/mem_wb_fwd_lookup.sv
// mem_wb_fwd_lookup
// Combinational priority match of one register query against DEPTH
// in-flight entries. Entry 0 is the youngest and wins over older matches.
// Ports:
//   i_valid/i_regwrite/i_memtoreg : per-entry control bits
//   i_rd/i_data/i_result          : per-entry payload
//   i_query                       : register index being looked up
//   o_hit                         : some entry will write i_query
//   o_val                         : that entry's write-back value, else 0
module mem_wb_fwd_lookup
  import mem_wb_pipe_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int RBITS = RBITS_DEF,
  parameter int DEPTH = 1
) (
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [DEPTH-1:0]            i_regwrite,
  input  logic [DEPTH-1:0]            i_memtoreg,
  input  logic [DEPTH-1:0][RBITS-1:0] i_rd,
  input  logic [DEPTH-1:0][NBITS-1:0] i_data,
  input  logic [DEPTH-1:0][NBITS-1:0] i_result,
  input  logic [RBITS-1:0]            i_query,
  output logic                        o_hit,
  output logic [NBITS-1:0]            o_val
);

  // Walk from oldest to youngest so the youngest match is assigned last.
  always_comb begin
    o_hit = 1'b0;
    o_val = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_valid[k] && i_regwrite[k] && (i_rd[k] == i_query) &&
          (i_query != RBITS'(ZERO_REG))) begin
        o_hit = 1'b1;
        o_val = i_memtoreg[k] ? i_data[k] : i_result[k];
      end
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe
// Parametrised MEM/WB pipeline register: DEPTH stages between the MEM
// stage and write-back, with stall, flush, x0 write suppression, a
// pre-muxed write-back value and two forwarding lookups (rs, rt) that
// search every registered stage, youngest first.
// Ports:
//   i_clk, i_rst (async, active-low), i_stall, i_flush
//   bus            : mem_wb_pipe_if.slave (MEM_* in, WB_* out)
//   i_rs, i_rt     : forwarding queries
//   o_fwd_hit_*/o_fwd_val_* : forwarding results
//   o_retire_cnt   : retired-entry counter, only with MEM_WB_PIPE_RETIRE_CNT_EN
// Optional feature macro: MEM_WB_PIPE_RETIRE_CNT_EN
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int RBITS = RBITS_DEF,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_flush,
  mem_wb_pipe_if.slave     bus,
  input  logic [RBITS-1:0] i_rs,
  input  logic [RBITS-1:0] i_rt,
  output logic             o_fwd_hit_rs,
  output logic [NBITS-1:0] o_fwd_val_rs,
  output logic             o_fwd_hit_rt,
  output logic [NBITS-1:0] o_fwd_val_rt
`ifdef MEM_WB_PIPE_RETIRE_CNT_EN
  ,
  output logic [31:0]      o_retire_cnt
`endif
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("mem_wb_pipe: DEPTH must be within 1..%0d", MAX_DEPTH);
  end

  typedef struct packed {
    logic             valid;
    logic             memtoreg;
    logic             regwrite;
    logic [RBITS-1:0] rd;
    logic [NBITS-1:0] data;
    logic [NBITS-1:0] result;
  } entry_t;

  entry_t r_stage [DEPTH];
  entry_t w_capture;
  entry_t w_last;

  // regwrite is only carried for real entries that target a non-zero register.
  always_comb begin
    w_capture          = '0;
    w_capture.valid    = bus.MEM_valid;
    w_capture.memtoreg = bus.MEM_memtoreg;
    w_capture.regwrite = bus.MEM_regwrite & bus.MEM_valid &
                         (bus.MEM_rd != RBITS'(ZERO_REG));
    w_capture.rd       = bus.MEM_rd;
    w_capture.data     = bus.MEM_data;
    w_capture.result   = bus.MEM_result;
  end

  // Flush takes priority over stall; it kills the control bits only, so the
  // payload fields keep their old contents and MEM inputs are dropped.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (i_flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k].valid    <= 1'b0;
        r_stage[k].regwrite <= 1'b0;
        r_stage[k].memtoreg <= 1'b0;
      end
    end else if (!i_stall) begin
      r_stage[0] <= w_capture;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign w_last = r_stage[DEPTH-1];

  assign bus.WB_valid    = w_last.valid;
  assign bus.WB_data     = w_last.data;
  assign bus.WB_result   = w_last.result;
  assign bus.WB_rd       = w_last.rd;
  assign bus.WB_memtoreg = w_last.memtoreg;
  // Gated again here so a stale regwrite bit can never cause a write.
  assign bus.WB_regwrite = w_last.valid & w_last.regwrite;
  assign bus.WB_value    = w_last.memtoreg ? w_last.data : w_last.result;

  logic [DEPTH-1:0]            w_valid;
  logic [DEPTH-1:0]            w_regwrite;
  logic [DEPTH-1:0]            w_memtoreg;
  logic [DEPTH-1:0][RBITS-1:0] w_rd;
  logic [DEPTH-1:0][NBITS-1:0] w_data;
  logic [DEPTH-1:0][NBITS-1:0] w_result;

  always_comb begin
    w_valid    = '0;
    w_regwrite = '0;
    w_memtoreg = '0;
    w_rd       = '0;
    w_data     = '0;
    w_result   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_valid[k]    = r_stage[k].valid;
      w_regwrite[k] = r_stage[k].regwrite;
      w_memtoreg[k] = r_stage[k].memtoreg;
      w_rd[k]       = r_stage[k].rd;
      w_data[k]     = r_stage[k].data;
      w_result[k]   = r_stage[k].result;
    end
  end

  mem_wb_fwd_lookup #(.NBITS(NBITS), .RBITS(RBITS), .DEPTH(DEPTH)) u_fwd_rs (
    .i_valid    (w_valid),
    .i_regwrite (w_regwrite),
    .i_memtoreg (w_memtoreg),
    .i_rd       (w_rd),
    .i_data     (w_data),
    .i_result   (w_result),
    .i_query    (i_rs),
    .o_hit      (o_fwd_hit_rs),
    .o_val      (o_fwd_val_rs)
  );

  mem_wb_fwd_lookup #(.NBITS(NBITS), .RBITS(RBITS), .DEPTH(DEPTH)) u_fwd_rt (
    .i_valid    (w_valid),
    .i_regwrite (w_regwrite),
    .i_memtoreg (w_memtoreg),
    .i_rd       (w_rd),
    .i_data     (w_data),
    .i_result   (w_result),
    .i_query    (i_rt),
    .o_hit      (o_fwd_hit_rt),
    .o_val      (o_fwd_val_rt)
  );

`ifdef MEM_WB_PIPE_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Counts entries actually leaving the final stage; wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                     r_retire_cnt <= '0;
    else if (w_last.valid && !i_stall && !i_flush)  r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign o_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline register, successor to the single-stage MEM/WB latch.
- Carries load data, ALU result, destination register and the memtoreg/regwrite controls through DEPTH register stages to write-back.
- Adds a valid bit, stall, flush, x0 write suppression, a pre-muxed write-back value, and two forwarding lookup ports that search all in-flight stages.
- Sits between the MEM stage and the register file / forwarding unit.

Parameters:
- NBITS, 32, data/result width.
- RBITS, 5, register index width.
- DEPTH, 1, number of register stages (1..4). Values outside 1..4 are rejected at elaboration.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-low.
- i_stall  in  1  hold all stages.
- i_flush  in  1  kill all in-flight entries.
- MEM_valid  in  1  entry present.
- MEM_data  in  NBITS  load data.
- MEM_result  in  NBITS  ALU result.
- MEM_rd  in  RBITS  destination register.
- MEM_memtoreg  in  1  select data (1) or result (0).
- MEM_regwrite  in  1  write enable.
- i_rs  in  RBITS  forwarding query A.
- i_rt  in  RBITS  forwarding query B.
- WB_valid  out  1  final-stage valid.
- WB_data  out  NBITS  final-stage load data.
- WB_result  out  NBITS  final-stage ALU result.
- WB_rd  out  RBITS  final-stage destination register.
- WB_memtoreg  out  1  final-stage select.
- WB_regwrite  out  1  final-stage write enable, gated by valid.
- WB_value  out  NBITS  memtoreg ? data : result, from the final stage.
- o_fwd_hit_rs  out  1  forwarding hit, query A.
- o_fwd_val_rs  out  NBITS  forwarding value, query A.
- o_fwd_hit_rt  out  1  forwarding hit, query B.
- o_fwd_val_rt  out  NBITS  forwarding value, query B.

Behaviour:
- Reset (i_rst=0, asynchronous): all stage registers clear to 0, so every WB_* output is 0. Forwarding hits are 0 and forwarding values are 0. Release is sampled at the next rising edge.
- Pipeline: stage 0 captures MEM_* every edge unless stalled. Stage k captures stage k-1. WB_* come from stage DEPTH-1.
- Latency is DEPTH cycles: MEM inputs at edge n appear on WB_* after edge n+DEPTH-1.
- Capture rule: stored regwrite = MEM_regwrite & MEM_valid & (MEM_rd != 0). Writes to x0 are never carried.
- i_stall=1: every stage holds its value, including the final stage.
- i_flush=1: at the edge, valid, regwrite and memtoreg clear in all stages. Data, result and rd keep old contents. MEM inputs on a flush edge are discarded.
- Simultaneous flush and stall: flush wins.
- WB_regwrite = stage valid & stage regwrite. This holds even if a stage register were corrupted.
- Forwarding (combinational over registered stages only, no MEM_* bypass):
  - Search order is youngest first: stage 0, then 1, and so on.
  - Hit when valid & regwrite & rd == query & query != 0.
  - Value is the hitting stage's memtoreg ? data : result.
  - No hit: hit=0, value=0.
  - Multiple matches: the youngest stage wins.
- Reset asserted mid-stream: all entries are lost immediately, with no partial write-back.

Optional Feature:
- Macro MEM_WB_PIPE_RETIRE_CNT_EN.
- Defined: adds output o_retire_cnt, 32 bits.
  - Increments on each rising edge where WB_valid=1 and i_stall=0 and i_flush=0.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by reset.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - NBITS/RBITS defaults.
  - An entry struct {valid, memtoreg, regwrite, rd, data, result}.
  - The ZERO_REG constant (0).
  - The MAX_DEPTH constant (4).
- One sub-module, mem_wb_fwd_lookup: combinational priority match of one query over DEPTH entries. Instantiated twice, once for rs and once for rt.

Test Plan:
- Reset with DEPTH=1: hold i_rst=0, drive data=8, result=9, rd=7, memtoreg=1, regwrite=1, valid=1. All WB_* stay 0. After release, the next edge gives WB_data=8, WB_result=9, WB_rd=7, WB_value=8, WB_regwrite=1.
- DEPTH=3 latency: inject result=0x11, rd=5, memtoreg=0 at edge n. WB_rd=5 and WB_value=0x11 appear after edge n+2, not earlier.
- Stall/flush with DEPTH=2:
  - Stall 3 cycles: outputs frozen.
  - Flush together with stall: WB_valid=0 and WB_regwrite=0 after that edge, WB_data unchanged.
- x0 suppression: rd=0, regwrite=1, valid=1 gives WB_regwrite=0. Query i_rs=0 gives o_fwd_hit_rs=0.
- Forwarding priority with DEPTH=3:
  - Stage 2 holds rd=4, result=0xA. Stage 0 holds rd=4, memtoreg=1, data=0xB.
  - i_rs=4 gives hit=1, value=0xB.
  - i_rt=6 gives hit=0, value=0.
- Retire counter (macro defined): 5 valid entries, with 1 stalled cycle and 1 flush. o_retire_cnt counts exactly the unstalled, unflushed WB_valid edges. Preload near 0xFFFFFFFF to confirm wrap to 0.
